ir_key_event: RTL and testbench

//  Consumes 32-bit NEC frames from the IR receiver stage (ready pulse + data word) and turns them into key events.

---
 rtl/ir_pkg.sv | 26 ++
 rtl/ir_event_fifo.sv | 61 ++++++
 rtl/ir_key_event.sv | 144 ++++++++++++++
 tb/tb_ir_key_event.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared definitions for the NEC key-event block: FSM states, frame field layout, event record layout.
package ir_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } key_state_t;

    localparam int ADDR_LSB = 0;
    localparam int ADDR_W   = 16;
    localparam int CMD_LSB  = 16;
    localparam int CMD_W    = 8;
    localparam int NCMD_LSB = 24;
    localparam int NCMD_W   = 8;

    // Event record: {repeat, addr, cmd}
    localparam int EVT_W        = 1 + ADDR_W + CMD_W;
    localparam int EVT_CMD_LSB  = 0;
    localparam int EVT_ADDR_LSB = CMD_W;
    localparam int EVT_REP_BIT  = CMD_W + ADDR_W;

    function automatic logic frame_intact(input logic [31:0] frame);
        return frame[NCMD_LSB +: NCMD_W] == ~frame[CMD_LSB +: CMD_W];
    endfunction

endpackage

// File: rtl/ir_event_fifo.sv
// Show-ahead synchronous FIFO for key events with a sticky overflow flag.
// Head data reads as zero while empty so idle outputs stay quiet.
module ir_event_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge iCLK) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ir_key_event.sv
// NEC frame to key-event converter: edge capture, complement check, press/repeat FSM with release timeout.
// Optional address filtering is enabled by defining IR_ADDR_FILTER_EN.
// Consumer handshake: an event transfers on any cycle where oKEY_VALID && iKEY_READY; head fields are stable while oKEY_VALID is high and not accepted.
module ir_key_event
    import ir_pkg::*;
#(
    parameter int          HOLD_CYC   = 7_500_000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] ADDR_MATCH = 16'h0000
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iDATA_READY,
    input  logic [31:0] iDATA,
    output logic        oKEY_VALID,
    input  logic        iKEY_READY,
    output logic [7:0]  oKEY_CODE,
    output logic [15:0] oKEY_ADDR,
    output logic        oKEY_REPEAT,
    output logic        oKEY_HELD,
    output logic        oOVERFLOW,
    input  logic        iCLR_OVF
);

`ifdef IR_ADDR_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    localparam int            TW      = $clog2(HOLD_CYC + 1);
    localparam logic [TW-1:0] TIMEOUT = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] T_ONE   = TW'(1);

    logic                   rdy_q;
    logic                   cap_q;
    logic                   frame_v;
    logic [31:0]            frame_q;
    logic                   addr_ok;
    logic                   frame_ok;
    logic [ADDR_W+CMD_W-1:0] frame_code;

    key_state_t             state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [ADDR_W+CMD_W-1:0] code_q, code_d;
    logic                   push;
    logic                   push_rep;
    logic [EVT_W-1:0]       push_data;
    logic [EVT_W-1:0]       head;
    logic                   fifo_empty;

    // Rise detect, then latch the word one cycle later when the receiver has it settled.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            rdy_q   <= 1'b0;
            cap_q   <= 1'b0;
            frame_v <= 1'b0;
            frame_q <= '0;
        end else begin
            rdy_q   <= iDATA_READY;
            cap_q   <= iDATA_READY && !rdy_q;
            frame_v <= cap_q;
            if (cap_q) begin
                frame_q <= iDATA;
            end
        end
    end

    assign addr_ok    = !FILTER_EN || (frame_q[ADDR_LSB +: ADDR_W] == ADDR_MATCH);
    assign frame_ok   = frame_v && frame_intact(frame_q) && addr_ok;
    assign frame_code = {frame_q[ADDR_LSB +: ADDR_W], frame_q[CMD_LSB +: CMD_W]};

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        code_d   = code_q;
        push     = 1'b0;
        push_rep = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (frame_ok) begin
                    push    = 1'b1;
                    code_d  = frame_code;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                // A frame on the timeout cycle keeps the key held.
                if (frame_ok) begin
                    push     = 1'b1;
                    push_rep = (frame_code == code_q);
                    code_d   = frame_code;
                    timer_d  = '0;
                end else if (timer_q == TIMEOUT) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    assign push_data = {push_rep, frame_code};

    ir_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .push      (push),
        .push_data (push_data),
        .pop       (iKEY_READY),
        .clr_ovf   (iCLR_OVF),
        .rd_data   (head),
        .empty     (fifo_empty),
        .overflow  (oOVERFLOW)
    );

    assign oKEY_VALID  = !fifo_empty;
    assign oKEY_CODE   = head[EVT_CMD_LSB +: CMD_W];
    assign oKEY_ADDR   = head[EVT_ADDR_LSB +: ADDR_W];
    assign oKEY_REPEAT = head[EVT_REP_BIT];
    assign oKEY_HELD   = (state_q == ST_HELD);

endmodule

// File: tb/tb_ir_key_event.sv
// Bench for ir_key_event: frame-level reference model checked every cycle, plus literal spot checks.
module tb_ir_key_event;

    localparam int HOLD  = 1000;
    localparam int DEPTH = 4;
`ifdef IR_ADDR_FILTER_EN
    localparam logic [15:0] AM = 16'h00FF;
`else
    localparam logic [15:0] AM = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_ready = 1'b0;
    logic [31:0] data = '0;
    logic        key_valid;
    logic        key_ready = 1'b0;
    logic [7:0]  key_code;
    logic [15:0] key_addr;
    logic        key_repeat;
    logic        key_held;
    logic        ovf;
    logic        clr_ovf = 1'b0;

    always #10 clk = ~clk;

    ir_key_event #(
        .HOLD_CYC   (HOLD),
        .FIFO_DEPTH (DEPTH),
        .ADDR_MATCH (AM)
    ) dut (
        .iCLK        (clk),
        .iRST_n      (rst_n),
        .iDATA_READY (data_ready),
        .iDATA       (data),
        .oKEY_VALID  (key_valid),
        .iKEY_READY  (key_ready),
        .oKEY_CODE   (key_code),
        .oKEY_ADDR   (key_addr),
        .oKEY_REPEAT (key_repeat),
        .oKEY_HELD   (key_held),
        .oOVERFLOW   (ovf),
        .iCLR_OVF    (clr_ovf)
    );

    typedef struct {
        int          a;
        logic [31:0] d;
    } frame_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_a   = 0;
    frame_t      sched_q[$];
    logic [24:0] exp_q[$];
    bit          m_have;
    int          m_last_a;
    logic [23:0] m_code;
    bit          m_ovf;
    bit          m_held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] c, input logic [15:0] a);
        return {~c, c, a};
    endfunction

    function automatic logic [24:0] rec(input logic r, input logic [15:0] a, input logic [7:0] c);
        return {r, a, c};
    endfunction

    function automatic bit model_accepts(input logic [31:0] d);
        bit ok;
        ok = (d[31:24] == ~d[23:16]);
`ifdef IR_ADDR_FILTER_EN
        ok = ok && (d[15:0] == AM);
`endif
        return ok;
    endfunction

    // Reference model: a frame driven after edge k is acted on at edge k+3.
    initial begin : monitor
        forever begin
            frame_t      f;
            logic [23:0] c;
            bit          r;
            bit          dropped;
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                exp_q.delete();
                sched_q.delete();
                m_have = 1'b0;
                m_ovf  = 1'b0;
            end else begin
                dropped = 1'b0;
                if (key_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                while (sched_q.size() > 0 && sched_q[0].a <= cyc) begin
                    f = sched_q.pop_front();
                    if (f.a == cyc && model_accepts(f.d)) begin
                        c = {f.d[15:0], f.d[23:16]};
                        r = m_have && ((cyc - m_last_a) <= HOLD) && (c == m_code);
                        m_have   = 1'b1;
                        m_last_a = cyc;
                        m_code   = c;
                        if (exp_q.size() < DEPTH) exp_q.push_back({r, c});
                        else dropped = 1'b1;
                    end
                end
                if (clr_ovf) m_ovf = 1'b0;
                if (dropped) m_ovf = 1'b1;
            end
            m_held = m_have && ((cyc - m_last_a) < HOLD);
            @(negedge clk);
            check("held", {31'd0, key_held}, {31'd0, m_held});
            check("valid", {31'd0, key_valid}, {31'd0, exp_q.size() > 0});
            if (key_valid && exp_q.size() > 0)
                check("head", {7'd0, key_repeat, key_addr, key_code}, {7'd0, exp_q[0]});
            check("overflow", {31'd0, ovf}, {31'd0, m_ovf});
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] d, input int len);
        @(posedge clk);
        #1;
        data_ready = 1'b1;
        data = d;
        sched_q.push_back('{cyc + 3, d});
        last_a = cyc + 3;
        wait_cycles(len);
        data_ready = 1'b0;
        wait_cycles(4);
    endtask

    task automatic head_check(input string name, input logic [24:0] exp);
        check({name, "_valid"}, {31'd0, key_valid}, 32'd1);
        check(name, {7'd0, key_repeat, key_addr, key_code}, {7'd0, exp});
        key_ready = 1'b1;
        wait_cycles(1);
        key_ready = 1'b0;
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        wait_cycles(3);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_code", {24'd0, key_code}, 32'd0);
        check("rst_addr", {16'd0, key_addr}, 32'd0);
        check("rst_repeat", {31'd0, key_repeat}, 32'd0);
        check("rst_held", {31'd0, key_held}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        wait_cycles(3);

        // Long ready level gives one press event
        send_frame(32'hBA45_00FF, 50);
        check("t1_held", {31'd0, key_held}, 32'd1);
        head_check("t1_event", 25'h000FF45);
        check("t1_single", {31'd0, key_valid}, 32'd0);
        wait_cycles(HOLD + 20);
        check("t1_release", {31'd0, key_held}, 32'd0);

        // Press then two auto-repeats, released afterwards without an event
        for (int i = 0; i < 3; i++) begin
            send_frame(32'hBA45_00FF, 2);
            wait_cycles(500);
        end
        wait_cycles(HOLD + 10);
        check("t2_release", {31'd0, key_held}, 32'd0);
        head_check("t2_ev0", rec(1'b0, 16'h00FF, 8'h45));
        head_check("t2_ev1", rec(1'b1, 16'h00FF, 8'h45));
        head_check("t2_ev2", rec(1'b1, 16'h00FF, 8'h45));
        check("t2_empty", {31'd0, key_valid}, 32'd0);

        // Corrupt complement is ignored while held
        send_frame(32'hBA45_00FF, 1);
        send_frame(32'h0045_00FF, 1);
        check("t3_held", {31'd0, key_held}, 32'd1);
        head_check("t3_event", rec(1'b0, 16'h00FF, 8'h45));
        check("t3_no_bad", {31'd0, key_valid}, 32'd0);
        wait_cycles(HOLD + 20);

        // Six events into a four-deep queue
        for (int i = 0; i < 6; i++) send_frame(mk(8'h10 + 8'(i), 16'h00FF), 1);
        check("t4_ovf", {31'd0, ovf}, 32'd1);
        for (int i = 0; i < 4; i++) head_check("t4_drain", rec(1'b0, 16'h00FF, 8'h10 + 8'(i)));
        check("t4_empty", {31'd0, key_valid}, 32'd0);
        clr_ovf = 1'b1;
        wait_cycles(1);
        clr_ovf = 1'b0;
        check("t4_clr", {31'd0, ovf}, 32'd0);

        // Code change inside the hold window is a new press
        send_frame(mk(8'h45, 16'h00FF), 1);
        send_frame(mk(8'h46, 16'h00FF), 1);
        check("t5_held", {31'd0, key_held}, 32'd1);
        head_check("t5_ev0", rec(1'b0, 16'h00FF, 8'h45));
        head_check("t5_ev1", rec(1'b0, 16'h00FF, 8'h46));

        // Frame on the timeout cycle is a repeat; one cycle later it is a new press
        while (cyc < last_a + HOLD - 4) wait_cycles(1);
        send_frame(mk(8'h46, 16'h00FF), 1);
        check("t6_held", {31'd0, key_held}, 32'd1);
        head_check("t6_edge", rec(1'b1, 16'h00FF, 8'h46));
        while (cyc < last_a + HOLD - 3) wait_cycles(1);
        send_frame(mk(8'h46, 16'h00FF), 1);
        head_check("t6_late", rec(1'b0, 16'h00FF, 8'h46));

        // Free-running consumer
        key_ready = 1'b1;
        send_frame(mk(8'h21, 16'h00FF), 3);
        send_frame(mk(8'h21, 16'h00FF), 3);
        check("t7_drained", {31'd0, key_valid}, 32'd0);
        key_ready = 1'b0;

        // Reset with one event queued and another frame in flight
        send_frame(mk(8'h30, 16'h00FF), 1);
        @(posedge clk);
        #1;
        data_ready = 1'b1;
        data = mk(8'h31, 16'h00FF);
        sched_q.push_back('{cyc + 3, data});
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(5);
        check("t8_flush", {31'd0, key_valid}, 32'd0);
        check("t8_held", {31'd0, key_held}, 32'd0);

        // Foreign remote address
        send_frame(mk(8'h55, 16'h1234), 1);
`ifdef IR_ADDR_FILTER_EN
        check("t9_foreign", {31'd0, key_valid}, 32'd0);
        send_frame(mk(8'h55, 16'h00FF), 1);
        head_check("t9_match", rec(1'b0, 16'h00FF, 8'h55));
`else
        head_check("t9_any_addr", rec(1'b0, 16'h1234, 8'h55));
`endif
        wait_cycles(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
